// File: rtl/lamp_sequencer.sv
// Lamp sequencer: one wrapping step counter with a clock prescaler and a synchronous clear.
// It drives two lamp groups in one of four modes: off, left chase, right chase or hazard.
// It sits between the turn/hazard controller and the LED outputs.
//
// Ports:
//   clock          in   1      system clock, rising edge
//   reset_n        in   1      asynchronous active-low reset
//   reset_counter  in   1      synchronous active-low clear of counters and lamp pattern
//   enable         in   1      1 = prescaler/step advance, 0 = hold
//   mode           in   2      00 off, 01 left chase, 10 right chase, 11 hazard
//   step_count     out  CW     current step, 0..PERIOD-1
//   wrap           out  1      one-clock pulse after the step PERIOD-1 -> 0 transition
//   left_lamps     out  LAMPS  left group, bit 0 innermost
//   right_lamps    out  LAMPS  right group, bit 0 innermost
module lamp_sequencer #(
  parameter int unsigned LAMPS    = 3,
  parameter int unsigned PERIOD   = 7,
  parameter int unsigned TICK_DIV = 1,
  localparam int unsigned CW      = $clog2(PERIOD)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             reset_counter,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic [CW-1:0]    step_count,
  output logic             wrap,
  output logic [LAMPS-1:0] left_lamps,
  output logic [LAMPS-1:0] right_lamps
);

  // Keep the prescaler at least one bit wide even when TICK_DIV is 1.
  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // The chase phase has LAMPS+1 states: 0..LAMPS lamps lit.
  localparam int unsigned PW = $clog2(LAMPS + 1);

  localparam logic [DW-1:0] DivLast   = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] StepLast  = CW'(PERIOD - 1);
  localparam logic [PW-1:0] PhaseLast = PW'(LAMPS);

  typedef enum logic [1:0] {
    ModeOff    = 2'b00,
    ModeLeft   = 2'b01,
    ModeRight  = 2'b10,
    ModeHazard = 2'b11
  } mode_e;

  mode_e           mode_q;
  logic [DW-1:0]   div_q;
  logic [PW-1:0]   phase_q;
  logic [PW-1:0]   phase_next;
  logic [LAMPS-1:0] init_pattern;
  logic [LAMPS-1:0] chase_pattern;
  logic            load;
  logic            tick;

  // Lowest p bits set.
  function automatic logic [LAMPS-1:0] thermometer(input logic [PW-1:0] p);
    logic [LAMPS-1:0] t;
    t = '0;
    for (int i = 0; i < int'(LAMPS); i++) begin
      t[i] = (i < int'(p));
    end
    return t;
  endfunction

  assign phase_next    = (phase_q == PhaseLast) ? '0 : phase_q + PW'(1);
  assign chase_pattern = thermometer(phase_next);
  assign init_pattern  = (mode == 2'b11) ? '1 : '0;

  // A mode change restarts the sequence exactly like a clear.
  assign load = !reset_counter || (mode != mode_q);
  assign tick = enable && (div_q == DivLast);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= ModeOff;
      div_q       <= '0;
      phase_q     <= '0;
      step_count  <= '0;
      wrap        <= 1'b0;
      left_lamps  <= '0;
      right_lamps <= '0;
    end else if (load) begin
      mode_q      <= mode_e'(mode);
      div_q       <= '0;
      phase_q     <= '0;
      step_count  <= '0;
      wrap        <= 1'b0;
      left_lamps  <= init_pattern;
      right_lamps <= init_pattern;
    end else if (tick) begin
      div_q      <= '0;
      step_count <= (step_count == StepLast) ? '0 : step_count + CW'(1);
      wrap       <= (step_count == StepLast);
      unique case (mode_q)
        ModeOff: begin
          left_lamps  <= '0;
          right_lamps <= '0;
        end
        ModeLeft: begin
          phase_q     <= phase_next;
          left_lamps  <= chase_pattern;
          right_lamps <= '0;
        end
        ModeRight: begin
          phase_q     <= phase_next;
          left_lamps  <= '0;
          right_lamps <= chase_pattern;
        end
        ModeHazard: begin
          left_lamps  <= ~left_lamps;
          right_lamps <= ~right_lamps;
        end
      endcase
    end else begin
      // Enabled between ticks advances the prescaler; disabled holds it.
      if (enable) begin
        div_q <= div_q + DW'(1);
      end
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lamp_sequencer.sv
// Directed bench for lamp_sequencer. Three instances share one stimulus:
//   a: LAMPS=3 PERIOD=7 TICK_DIV=1
//   b: LAMPS=3 PERIOD=7 TICK_DIV=4
//   c: LAMPS=1 PERIOD=2 TICK_DIV=1
module tb_lamp_sequencer;

  logic       clock;
  logic       reset_n;
  logic       reset_counter;
  logic       enable;
  logic [1:0] mode;

  logic [2:0] a_step, a_left, a_right;
  logic       a_wrap;
  logic [2:0] b_step, b_left, b_right;
  logic       b_wrap;
  logic [0:0] c_step, c_left, c_right;
  logic       c_wrap;

  int total = 0;
  int bad   = 0;

  lamp_sequencer #(.LAMPS(3), .PERIOD(7), .TICK_DIV(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .reset_counter(reset_counter), .enable(enable),
    .mode(mode), .step_count(a_step), .wrap(a_wrap), .left_lamps(a_left),
    .right_lamps(a_right)
  );

  lamp_sequencer #(.LAMPS(3), .PERIOD(7), .TICK_DIV(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .reset_counter(reset_counter), .enable(enable),
    .mode(mode), .step_count(b_step), .wrap(b_wrap), .left_lamps(b_left),
    .right_lamps(b_right)
  );

  lamp_sequencer #(.LAMPS(1), .PERIOD(2), .TICK_DIV(1)) dut_c (
    .clock(clock), .reset_n(reset_n), .reset_counter(reset_counter), .enable(enable),
    .mode(mode), .step_count(c_step), .wrap(c_wrap), .left_lamps(c_left),
    .right_lamps(c_right)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int st, input int wr, input int lf, input int rt);
    check_eq($sformatf("%s a.step", tag), 32'(a_step), st);
    check_eq($sformatf("%s a.wrap", tag), 32'(a_wrap), wr);
    check_eq($sformatf("%s a.left", tag), 32'(a_left), lf);
    check_eq($sformatf("%s a.right", tag), 32'(a_right), rt);
  endtask

  task automatic chk_b(input string tag, input int st, input int wr, input int lf, input int rt);
    check_eq($sformatf("%s b.step", tag), 32'(b_step), st);
    check_eq($sformatf("%s b.wrap", tag), 32'(b_wrap), wr);
    check_eq($sformatf("%s b.left", tag), 32'(b_left), lf);
    check_eq($sformatf("%s b.right", tag), 32'(b_right), rt);
  endtask

  task automatic chk_c(input string tag, input int st, input int wr, input int lf, input int rt);
    check_eq($sformatf("%s c.step", tag), 32'(c_step), st);
    check_eq($sformatf("%s c.wrap", tag), 32'(c_wrap), wr);
    check_eq($sformatf("%s c.left", tag), 32'(c_left), lf);
    check_eq($sformatf("%s c.right", tag), 32'(c_right), rt);
  endtask

  // Expected 3-lamp chase pattern for a phase 0..3.
  function automatic int therm3(input int p);
    case (p)
      0: return 0;
      1: return 1;
      2: return 3;
      default: return 7;
    endcase
  endfunction

  task automatic step_clk();
    @(posedge clock);
    #1;
  endtask

  // Asynchronous reset mid-cycle, check all instances cleared, release with given inputs.
  task automatic do_reset(input logic [1:0] m, input logic en);
    reset_n       = 1'b0;
    reset_counter = 1'b1;
    mode          = m;
    enable        = en;
    #2;
    chk_a("reset", 0, 0, 0, 0);
    chk_b("reset", 0, 0, 0, 0);
    chk_c("reset", 0, 0, 0, 0);
    step_clk();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n       = 1'b1;
    reset_counter = 1'b1;
    enable        = 1'b0;
    mode          = 2'b00;
    step_clk();

    // 1: hazard after reset release
    do_reset(2'b11, 1'b1);
    step_clk(); chk_a("t1 e1", 0, 0, 7, 7);
    step_clk(); chk_a("t1 e2", 1, 0, 0, 0);
    step_clk(); chk_a("t1 e3", 2, 0, 7, 7);

    // 2: count, wrap, left chase
    do_reset(2'b01, 1'b1);
    step_clk(); chk_a("t2 e1", 0, 0, 0, 0);
    for (int k = 2; k <= 16; k++) begin
      step_clk();
      chk_a($sformatf("t2 e%0d", k), (k - 1) % 7, ((k - 1) % 7 == 0) ? 1 : 0,
            therm3((k - 1) % 4), 0);
    end

    // 3: prescaler with a mid-run hold, right chase
    do_reset(2'b10, 1'b1);
    step_clk(); chk_b("t3 e1", 0, 0, 0, 0);
    for (int k = 2; k <= 4; k++) begin
      step_clk(); chk_b($sformatf("t3 e%0d", k), 0, 0, 0, 0);
    end
    step_clk(); chk_b("t3 e5", 1, 0, 0, 1);
    step_clk(); chk_b("t3 e6", 1, 0, 0, 1);
    step_clk(); chk_b("t3 e7", 1, 0, 0, 1);
    enable = 1'b0;
    for (int k = 8; k <= 10; k++) begin
      step_clk(); chk_b($sformatf("t3 hold%0d", k), 1, 0, 0, 1);
    end
    enable = 1'b1;
    step_clk(); chk_b("t3 e11", 1, 0, 0, 1);
    step_clk(); chk_b("t3 e12", 2, 0, 0, 3);
    for (int s = 3; s <= 7; s++) begin
      repeat (3) begin
        step_clk();
        chk_b($sformatf("t3 mid%0d", s), (s - 1) % 7, 0, 0, therm3((s - 1) % 4));
      end
      step_clk();
      chk_b($sformatf("t3 tick%0d", s), s % 7, (s == 7) ? 1 : 0, 0, therm3(s % 4));
    end
    step_clk(); chk_b("t3 after wrap", 0, 0, 0, therm3(3));

    // 4: synchronous clear
    do_reset(2'b11, 1'b1);
    step_clk(); chk_a("t4 e1", 0, 0, 7, 7);
    for (int k = 2; k <= 6; k++) begin
      step_clk();
      chk_a($sformatf("t4 e%0d", k), k - 1, 0, (k % 2 == 1) ? 7 : 0, (k % 2 == 1) ? 7 : 0);
    end
    reset_counter = 1'b0;
    step_clk(); chk_a("t4 clear", 0, 0, 7, 7);
    mode = 2'b01;
    step_clk(); chk_a("t4 clear+mode", 0, 0, 0, 0);
    step_clk(); chk_a("t4 clear held", 0, 0, 0, 0);
    reset_counter = 1'b1;
    step_clk(); chk_a("t4 release", 1, 0, 1, 0);

    // 5: mode switch while disabled
    do_reset(2'b01, 1'b1);
    step_clk(); chk_a("t5 e1", 0, 0, 0, 0);
    step_clk(); chk_a("t5 e2", 1, 0, 1, 0);
    step_clk(); chk_a("t5 e3", 2, 0, 3, 0);
    mode   = 2'b10;
    enable = 1'b0;
    step_clk(); chk_a("t5 switch", 0, 0, 0, 0);
    enable = 1'b1;
    step_clk(); chk_a("t5 r1", 1, 0, 0, 1);
    step_clk(); chk_a("t5 r2", 2, 0, 0, 3);
    step_clk(); chk_a("t5 r3", 3, 0, 0, 7);

    // 6: minimum parameters
    do_reset(2'b01, 1'b1);
    step_clk(); chk_c("t6 e1", 0, 0, 0, 0);
    step_clk(); chk_c("t6 e2", 1, 0, 1, 0);
    step_clk(); chk_c("t6 e3", 0, 1, 0, 0);
    step_clk(); chk_c("t6 e4", 1, 0, 1, 0);
    step_clk(); chk_c("t6 e5", 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
